// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 memory controller
package slc3_mem_pkg;

    localparam int WORD_W = 16;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic {
        INIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/slc3_mem_ctrl_if.sv
// rtl/slc3_mem_ctrl_if.sv - SRAM-style bus between the SLC-3 core and the memory controller
interface slc3_mem_ctrl_if;
    import slc3_mem_pkg::*;

    logic [15:0]       ADDR;
    logic              OE;
    logic              WE;
    logic [WORD_W-1:0] Data_to_SRAM;
    logic [WORD_W-1:0] Data_from_SRAM;

    modport master (
        output ADDR,
        output OE,
        output WE,
        output Data_to_SRAM,
        input  Data_from_SRAM
    );

    modport slave (
        input  ADDR,
        input  OE,
        input  WE,
        input  Data_to_SRAM,
        output Data_from_SRAM
    );

endinterface

// File: rtl/boot_rom.sv
// rtl/boot_rom.sv - combinational boot program image copied into RAM after reset
module boot_rom
    import slc3_mem_pkg::*;
#(
    parameter int AW         = 10,
    parameter int INIT_WORDS = 64
) (
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] data
);

    // Image word i is 16'hB00B + i*16'h0101; words past the image read as zero.
    always_comb begin
        data = '0;
        if (32'(addr) < 32'(INIT_WORDS)) begin
            data = 16'hB00B + 16'(addr) * 16'd257;
        end
    end

endmodule

// File: rtl/slc3_mem_ctrl.sv
// rtl/slc3_mem_ctrl.sv - boot-copying block RAM controller for the SLC-3 core
// Optional macro MEM_WRITE_PROTECT_EN drops DONE-state writes below PROTECT_TOP.
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          INIT_WORDS  = 64,
    parameter logic [15:0] PROTECT_TOP = 16'h0040
) (
    input  logic           Clk,
    input  logic           Reset,
    slc3_mem_ctrl_if.slave bus,
    output logic           Init_Done,
    output logic [7:0]     Err_Count
);

    localparam int AW = $clog2(DEPTH);

    mem_state_t        state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic [7:0]        err_q, err_d;

    logic [WORD_W-1:0] ram [DEPTH];
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] rom_data;

    logic              in_range;
    logic [AW-1:0]     idx;
    logic              wr_blocked;
    logic              drop;

    boot_rom #(
        .AW         (AW),
        .INIT_WORDS (INIT_WORDS)
    ) u_boot_rom (
        .addr (ptr_q),
        .data (rom_data)
    );

    // Range check on the full address before truncating, so nothing aliases.
    assign in_range = {1'b0, bus.ADDR} < 17'(DEPTH);
    assign idx      = bus.ADDR[AW-1:0];

`ifdef MEM_WRITE_PROTECT_EN
    assign wr_blocked = bus.ADDR < PROTECT_TOP;
`else
    logic unused_protect;
    assign unused_protect = ^PROTECT_TOP;
    assign wr_blocked     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
            dout_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // RAM has no reset: words beyond the boot image survive a Reset.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_wdata = rom_data;
        drop      = 1'b0;

        case (state_q)
            INIT: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == AW'(INIT_WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A write takes priority over a simultaneous read; output holds.
                if (!bus.WE) begin
                    if (in_range && !wr_blocked) begin
                        ram_we    = 1'b1;
                        ram_waddr = idx;
                        ram_wdata = bus.Data_to_SRAM;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (!bus.OE) begin
                    if (in_range) begin
                        dout_d = ram[idx];
                    end else begin
                        dout_d = '0;
                        drop   = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase

        if (drop && (err_q != ERR_MAX)) begin
            err_d = err_q + 8'd1;
        end
    end

    assign bus.Data_from_SRAM = dout_q;
    assign Init_Done          = (state_q == DONE);
    assign Err_Count          = err_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// tb/tb_slc3_mem_ctrl.sv - directed self-checking bench for slc3_mem_ctrl
module tb_slc3_mem_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Init_Done;
    logic [7:0] Err_Count;

    int n_checks;
    int n_fail;

    slc3_mem_ctrl_if bus ();

    slc3_mem_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .Init_Done (Init_Done),
        .Err_Count (Err_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Image word i = B00B + {i,i} for i < 64.
    function automatic logic [15:0] rom_model(input int i);
        logic [7:0] b;
        b = 8'(i);
        return 16'hB00B + {b, b};
    endfunction

    task automatic idle();
        bus.OE           = 1'b1;
        bus.WE           = 1'b1;
        bus.ADDR         = 16'h0000;
        bus.Data_to_SRAM = 16'h0000;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!Init_Done && n < 200) begin
            @(negedge Clk);
            n++;
        end
        n_checks++;
        if (n !== 64) begin
            n_fail++;
            $display("FAIL %s: Init_Done after %0d cycles, expected 64", name, n);
        end
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        bus.ADDR = a; bus.Data_to_SRAM = d; bus.WE = 1'b0; bus.OE = 1'b1;
        @(negedge Clk);
        idle();
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        bus.ADDR = a; bus.OE = 1'b0; bus.WE = 1'b1;
        @(negedge Clk);
        idle();
        n_checks++;
        if (bus.Data_from_SRAM !== exp) begin
            n_fail++;
            $display("FAIL %s: addr %h read %h, expected %h", name, a, bus.Data_from_SRAM, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        n_checks += 3;
        if (bus.Data_from_SRAM !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: %h expected 0000", bus.Data_from_SRAM);
        end
        if (Init_Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_init_done: %b expected 0", Init_Done);
        end
        if (Err_Count !== 8'h00) begin
            n_fail++; $display("FAIL reset_err: %h expected 00", Err_Count);
        end
        // CPU activity during the copy must be ignored.
        Reset = 1'b0;
        bus.OE = 1'b0; bus.WE = 1'b0; bus.ADDR = 16'h0400;
        wait_init("boot_latency");
        idle();
        n_checks += 2;
        if (Err_Count !== 8'h00) begin
            n_fail++; $display("FAIL init_err: %h expected 00", Err_Count);
        end
        if (bus.Data_from_SRAM !== 16'h0000) begin
            n_fail++; $display("FAIL init_data: %h expected 0000", bus.Data_from_SRAM);
        end
    endtask

    task automatic test_boot_copy();
        // Pipelined sweep: each negedge checks the previous address and issues the next.
        bus.WE = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.ADDR = 16'(i); bus.OE = 1'b0;
            @(negedge Clk);
            n_checks++;
            if (bus.Data_from_SRAM !== rom_model(i)) begin
                n_fail++;
                $display("FAIL boot_copy: addr %0d read %h, expected %h", i, bus.Data_from_SRAM, rom_model(i));
            end
        end
        idle();
        read_check("boot_word0", 16'h0000, 16'hB00B);
        read_check("boot_word63", 16'h003F, 16'hEF4A);
    endtask

    task automatic test_read_latency();
        bus.ADDR = 16'h0005; bus.OE = 1'b0; bus.WE = 1'b1;
        @(negedge Clk);
        bus.OE = 1'b1; bus.ADDR = 16'h0007;
        n_checks++;
        if (bus.Data_from_SRAM !== 16'hB510) begin
            n_fail++; $display("FAIL read_latency: %h expected B510", bus.Data_from_SRAM);
        end
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (bus.Data_from_SRAM !== 16'hB510) begin
            n_fail++; $display("FAIL read_hold: %h expected B510", bus.Data_from_SRAM);
        end
    endtask

    task automatic test_write_readback();
        write_word(16'h0100, 16'hBEEF);
        read_check("write_readback", 16'h0100, 16'hBEEF);
        bus.ADDR = 16'h0101; bus.Data_to_SRAM = 16'hCAFE; bus.OE = 1'b0; bus.WE = 1'b0;
        @(negedge Clk);
        idle();
        n_checks++;
        if (bus.Data_from_SRAM !== 16'hBEEF) begin
            n_fail++; $display("FAIL write_wins_hold: %h expected BEEF", bus.Data_from_SRAM);
        end
        read_check("write_wins_data", 16'h0101, 16'hCAFE);
        n_checks++;
        if (Err_Count !== 8'h00) begin
            n_fail++; $display("FAIL write_err: %h expected 00", Err_Count);
        end
    endtask

    task automatic test_out_of_range();
        read_check("oor_read", 16'h0400, 16'h0000);
        n_checks++;
        if (Err_Count !== 8'h01) begin
            n_fail++; $display("FAIL oor_err1: %h expected 01", Err_Count);
        end
        write_word(16'h0400, 16'h1111);
        n_checks++;
        if (Err_Count !== 8'h02) begin
            n_fail++; $display("FAIL oor_err2: %h expected 02", Err_Count);
        end
        read_check("oor_no_alias", 16'h0000, 16'hB00B);
        for (int i = 0; i < 300; i++) begin
            bus.ADDR = (i % 2 == 0) ? 16'hFFFF : 16'h0400 + 16'(i);
            bus.OE = 1'b0;
            bus.WE = (i % 3 == 0) ? 1'b0 : 1'b1;
            @(negedge Clk);
        end
        idle();
        @(negedge Clk);
        n_checks++;
        if (Err_Count !== 8'hFF) begin
            n_fail++; $display("FAIL oor_saturate: %h expected FF", Err_Count);
        end
    endtask

    task automatic test_reset_mid_copy();
        write_word(16'h0200, 16'h1234);
        write_word(16'h0003, 16'h7777);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (30) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        n_checks += 3;
        if (Init_Done !== 1'b0) begin
            n_fail++; $display("FAIL midcopy_init_done: %b expected 0", Init_Done);
        end
        if (Err_Count !== 8'h00) begin
            n_fail++; $display("FAIL midcopy_err: %h expected 00", Err_Count);
        end
        if (bus.Data_from_SRAM !== 16'h0000) begin
            n_fail++; $display("FAIL midcopy_data: %h expected 0000", bus.Data_from_SRAM);
        end
        Reset = 1'b0;
        wait_init("midcopy_latency");
        read_check("midcopy_keep_high", 16'h0200, 16'h1234);
        read_check("midcopy_rewrite_low", 16'h0003, 16'hB30E);
        read_check("midcopy_last_word", 16'h003F, 16'hEF4A);
    endtask

    task automatic test_write_protect();
        write_word(16'h0010, 16'hDEAD);
`ifdef MEM_WRITE_PROTECT_EN
        read_check("protect_low", 16'h0010, 16'hC01B);
        n_checks++;
        if (Err_Count !== 8'h01) begin
            n_fail++; $display("FAIL protect_err: %h expected 01", Err_Count);
        end
`else
        read_check("unprotected_low", 16'h0010, 16'hDEAD);
        n_checks++;
        if (Err_Count !== 8'h00) begin
            n_fail++; $display("FAIL unprotected_err: %h expected 00", Err_Count);
        end
`endif
        write_word(16'h0040, 16'h4040);
        read_check("protect_top_ok", 16'h0040, 16'h4040);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        idle();
        test_reset();
        test_boot_copy();
        test_read_latency();
        test_write_readback();
        test_out_of_range();
        test_reset_mid_copy();
        test_write_protect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
